// File: rtl/weight_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_ctrl_pkg
//  Description : Shared constants and mask helpers for the double-buffered
//                weight bank sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package weight_ctrl_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_LOAD    = 2'd1;
    localparam logic [1:0] c_ST_LAYER   = 2'd2;
    localparam logic [1:0] c_ST_OVERLAP = 2'd3;

    // Command codes carried on mode
    localparam logic [2:0] c_MODE_IDLE    = 3'd0;
    localparam logic [2:0] c_MODE_LOAD    = 3'd1;
    localparam logic [2:0] c_MODE_LAYER   = 3'd2;
    localparam logic [2:0] c_MODE_OVERLAP = 3'd3;

    // Bit positions inside the load event vector
    localparam int c_EV_LOAD  = 0;
    localparam int c_EV_LAYER = 1;
    localparam int c_EV_SWAP  = 2;

    // Widest MAC array the mask helpers can describe
    localparam int c_MAX_MACS = 1024;

    // Lower half of the MAC array: the load group
    function automatic logic [c_MAX_MACS-1:0] load_mask(input int n);
        logic [c_MAX_MACS-1:0] m;
        m = '0;
        for (int i = 0; i < c_MAX_MACS; i++) begin
            if (i < n / 2) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Upper half of the MAC array: the compute group
    function automatic logic [c_MAX_MACS-1:0] layer_mask(input int n);
        logic [c_MAX_MACS-1:0] m;
        m = '0;
        for (int i = 0; i < c_MAX_MACS; i++) begin
            if ((i >= n / 2) && (i < n)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bank_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : bank_tracker
//  Description : Holds the per-bank full flags and the compute (active) bank
//                pointer; updated by set/clear/swap strobes from the FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module bank_tracker
    import weight_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en_i,
    input  logic       set_bank_i,
    input  logic       clr_en_i,
    input  logic       clr_bank_i,
    input  logic       swap_i,
    output logic [1:0] full_o,
    output logic       active_o
);

    logic [1:0] full_q;
    logic [1:0] full_d;
    logic       active_q;

    // Apply clear then set so a simultaneous set on the other bank survives
    always_comb begin
        full_d = full_q;
        if (clr_en_i) begin
            full_d[clr_bank_i] = 1'b0;
        end
        if (set_en_i) begin
            full_d[set_bank_i] = 1'b1;
        end
    end

    // Register bank bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 2'b00;
            active_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (swap_i) begin
                active_q <= ~active_q;
            end
        end
    end

    assign full_o   = full_q;
    assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/weight_bank_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : weight_bank_seq_ctrl
//  Description : Ping-pong weight bank sequencer. Loads weights from a
//                valid/ready source into one bank while timing layer compute
//                on the other, swapping banks at layer boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_bank_seq_ctrl
    import weight_ctrl_pkg::*;
#(
    parameter int N_MACS       = 4,
    parameter int DEPTH        = 8,
    parameter int LAYER_CYCLES = 16,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic              w_valid,
    output logic              w_ready,
    output logic [AW-1:0]     w_addr,
    output logic              w_bank,
    output logic [N_MACS-1:0] weight_ctrl,
    output logic [2:0]        load,
    output logic              active_bank,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int c_LCW = $clog2(LAYER_CYCLES + 1);

    localparam logic [AW-1:0]    c_LD_LAST  = AW'(DEPTH - 1);
    localparam logic [c_LCW-1:0] c_LAY_LAST = c_LCW'(LAYER_CYCLES - 1);
    localparam logic [c_LCW-1:0] c_LAY_MAX  = c_LCW'(LAYER_CYCLES);

    localparam logic [c_MAX_MACS-1:0] c_LOAD_MASK_W  = load_mask(N_MACS);
    localparam logic [c_MAX_MACS-1:0] c_LAYER_MASK_W = layer_mask(N_MACS);
    localparam logic [N_MACS-1:0]     c_LOAD_MASK    = c_LOAD_MASK_W[N_MACS-1:0];
    localparam logic [N_MACS-1:0]     c_LAYER_MASK   = c_LAYER_MASK_W[N_MACS-1:0];

    logic [1:0]       state_q,   state_d;
    logic             tgt_q,     tgt_d;
    logic [AW-1:0]    ld_cnt_q,  ld_cnt_d;
    logic             ld_done_q, ld_done_d;
    logic [c_LCW-1:0] lay_cnt_q, lay_cnt_d;
    logic [2:0]       load_q,    load_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;

    logic       bk_set_en;
    logic       bk_set_bank;
    logic       bk_clr_en;
    logic       bk_clr_bank;
    logic       bk_swap;
    logic [1:0] full_w;
    logic       active_w;

    logic       load_phase;
    logic       accept;
    logic       ld_last_beat;
    logic       ld_fin;
    logic       lay_fin;

    bank_tracker u_bank (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (bk_set_en),
        .set_bank_i (bk_set_bank),
        .clr_en_i   (bk_clr_en),
        .clr_bank_i (bk_clr_bank),
        .swap_i     (bk_swap),
        .full_o     (full_w),
        .active_o   (active_w)
    );

    // Handshake and completion qualifiers derived from registered state
    assign load_phase   = (state_q == c_ST_LOAD) || (state_q == c_ST_OVERLAP);
    assign accept       = w_ready && w_valid;
    assign ld_last_beat = accept && (ld_cnt_q == c_LD_LAST);
    assign ld_fin       = ld_done_q || ld_last_beat;
    assign lay_fin      = (lay_cnt_q >= c_LAY_LAST);

    // Next-state, counter and strobe logic
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        ld_cnt_d    = ld_cnt_q;
        ld_done_d   = ld_done_q;
        lay_cnt_d   = lay_cnt_q;
        load_d      = 3'b000;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bk_set_en   = 1'b0;
        bk_set_bank = 1'b0;
        bk_clr_en   = 1'b0;
        bk_clr_bank = 1'b0;
        bk_swap     = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    case (mode)
                        c_MODE_IDLE: begin
                        end
                        c_MODE_LOAD: begin
                            if (full_w == 2'b11) begin
                                err_d = 1'b1;
                            end else begin
                                // Fill the compute bank first if it is empty
                                tgt_d             = full_w[active_w] ? ~active_w : active_w;
                                state_d           = c_ST_LOAD;
                                load_d[c_EV_LOAD] = 1'b1;
                            end
                        end
                        c_MODE_LAYER: begin
                            if (full_w[active_w]) begin
                                state_d            = c_ST_LAYER;
                                load_d[c_EV_LAYER] = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        c_MODE_OVERLAP: begin
                            if (full_w[active_w] && !full_w[~active_w]) begin
                                tgt_d              = ~active_w;
                                state_d            = c_ST_OVERLAP;
                                load_d[c_EV_LOAD]  = 1'b1;
                                load_d[c_EV_LAYER] = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end

            c_ST_LOAD: begin
                if (accept && !ld_last_beat) begin
                    ld_cnt_d = ld_cnt_q + AW'(1);
                end
                if (ld_last_beat) begin
                    bk_set_en   = 1'b1;
                    bk_set_bank = tgt_q;
                    ld_cnt_d    = '0;
                    done_d      = 1'b1;
                    state_d     = c_ST_IDLE;
                end
            end

            c_ST_LAYER: begin
                lay_cnt_d = lay_cnt_q + c_LCW'(1);
                if (lay_cnt_q == c_LAY_LAST) begin
                    bk_clr_en   = 1'b1;
                    bk_clr_bank = active_w;
                    // Hand compute over to the other bank only if it holds weights
                    if (full_w[~active_w]) begin
                        bk_swap           = 1'b1;
                        load_d[c_EV_SWAP] = 1'b1;
                    end
                    lay_cnt_d = '0;
                    done_d    = 1'b1;
                    state_d   = c_ST_IDLE;
                end
            end

            c_ST_OVERLAP: begin
                if (accept && !ld_last_beat) begin
                    ld_cnt_d = ld_cnt_q + AW'(1);
                end
                if (ld_last_beat) begin
                    ld_done_d = 1'b1;
                end
                // Layer counter saturates so the layer half stays complete
                if (lay_cnt_q != c_LAY_MAX) begin
                    lay_cnt_d = lay_cnt_q + c_LCW'(1);
                end
                if (ld_fin && lay_fin) begin
                    bk_clr_en         = 1'b1;
                    bk_clr_bank       = active_w;
                    bk_set_en         = 1'b1;
                    bk_set_bank       = ~active_w;
                    bk_swap           = 1'b1;
                    load_d[c_EV_SWAP] = 1'b1;
                    done_d            = 1'b1;
                    ld_cnt_d          = '0;
                    ld_done_d         = 1'b0;
                    lay_cnt_d         = '0;
                    state_d           = c_ST_IDLE;
                end
            end

            default: begin
                state_d = c_ST_IDLE;
            end
        endcase

        // Abort overrides everything: drop the partial work, keep bank state
        if (busy && (mode == c_MODE_IDLE)) begin
            state_d     = c_ST_IDLE;
            ld_cnt_d    = '0;
            ld_done_d   = 1'b0;
            lay_cnt_d   = '0;
            load_d      = 3'b000;
            done_d      = 1'b0;
            bk_set_en   = 1'b0;
            bk_clr_en   = 1'b0;
            bk_swap     = 1'b0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_IDLE;
            tgt_q     <= 1'b0;
            ld_cnt_q  <= '0;
            ld_done_q <= 1'b0;
            lay_cnt_q <= '0;
            load_q    <= 3'b000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            ld_cnt_q  <= ld_cnt_d;
            ld_done_q <= ld_done_d;
            lay_cnt_q <= lay_cnt_d;
            load_q    <= load_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // MAC weight-path enables decoded from the registered state
    always_comb begin
        case (state_q)
            c_ST_LOAD:    weight_ctrl = c_LOAD_MASK;
            c_ST_LAYER:   weight_ctrl = c_LAYER_MASK;
            c_ST_OVERLAP: weight_ctrl = {N_MACS{1'b1}};
            default:      weight_ctrl = '0;
        endcase
    end

    assign busy        = (state_q != c_ST_IDLE);
    assign w_ready     = load_phase && !ld_done_q;
    assign w_addr      = ld_cnt_q;
    assign w_bank      = load_phase && tgt_q;
    assign load        = load_q;
    assign done        = done_q;
    assign err         = err_q;
    assign active_bank = active_w;

endmodule
`default_nettype wire

// File: tb/tb_weight_bank_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_bank_seq_ctrl
//  Description : Directed self-checking bench for weight_bank_seq_ctrl
//                (N_MACS=4, DEPTH=8, LAYER_CYCLES=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_bank_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic       w_valid;
    logic       w_ready;
    logic [2:0] w_addr;
    logic       w_bank;
    logic [3:0] weight_ctrl;
    logic [2:0] load;
    logic       active_bank;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;
    int n_l1;

    weight_bank_seq_ctrl #(
        .N_MACS       (4),
        .DEPTH        (8),
        .LAYER_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_addr      (w_addr),
        .w_bank      (w_bank),
        .weight_ctrl (weight_ctrl),
        .load        (load),
        .active_bank (active_bank),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
            $error("check %s disagreed", tag);
        end
    endtask

    // One-cycle command strobe; returns in the cycle after acceptance
    task automatic cmd(input logic [2:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 3'd0;
        w_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy",   busy,               0);
        chk("rst_wctrl",  weight_ctrl,        0);
        chk("rst_wready", w_ready,            0);
        chk("rst_waddr",  w_addr,             0);
        chk("rst_load",   load,               0);
        chk("rst_done",   done,               0);
        chk("rst_err",    err,                0);
        chk("rst_active", active_bank,        0);
        chk("rst_full",   dut.u_bank.full_q,  0);

        // Plain load into bank 0 with w_valid held high
        w_valid = 1'b1;
        cmd(3'd1);
        chk("ld1_load0", load, 3'b001);
        chk("ld1_busy",  busy, 1);
        for (int i = 0; i < 8; i++) begin
            chk("ld1_wready", w_ready, 1);
            chk("ld1_waddr",  w_addr,  i);
            chk("ld1_wbank",  w_bank,  0);
            chk("ld1_wctrl",  weight_ctrl, 4'b0011);
            if (i == 1) chk("ld1_load_clr", load, 0);
            tick();
        end
        chk("ld1_done",   done,              1);
        chk("ld1_idle",   busy,              0);
        chk("ld1_wready0", w_ready,          0);
        chk("ld1_full",   dut.u_bank.full_q, 2'b01);
        tick();
        chk("ld1_done_clr", done, 0);

        // Layer on bank 0, no swap since bank 1 is empty
        cmd(3'd2);
        chk("lay_load1", load, 3'b010);
        n_l1 = 0;
        for (int i = 0; i < 16; i++) begin
            chk("lay_wctrl", weight_ctrl, 4'b1100);
            chk("lay_busy",  busy, 1);
            if (load[1]) n_l1++;
            tick();
        end
        chk("lay_l1_count", n_l1,              1);
        chk("lay_done",     done,              1);
        chk("lay_idle",     busy,              0);
        chk("lay_noswap",   load,              0);
        chk("lay_full",     dut.u_bank.full_q, 2'b00);
        chk("lay_active",   active_bank,       0);

        // Fill both banks, then overlap must be refused
        cmd(3'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("fill0_full", dut.u_bank.full_q, 2'b01);
        cmd(3'd1);
        chk("fill1_wbank", w_bank, 1);
        for (int i = 0; i < 8; i++) tick();
        chk("fill1_full", dut.u_bank.full_q, 2'b11);
        cmd(3'd3);
        chk("ovl_rej_err",  err,  1);
        chk("ovl_rej_busy", busy, 0);

        // Layer on bank 0 hands over to bank 1 with a swap pulse
        cmd(3'd2);
        for (int i = 0; i < 16; i++) tick();
        chk("swp_load",   load,              3'b100);
        chk("swp_active", active_bank,       1);
        chk("swp_done",   done,              1);
        chk("swp_full",   dut.u_bank.full_q, 2'b10);

        // Overlap: compute bank 1, load bank 0; load finishes after the layer
        w_valid = 1'b0;
        cmd(3'd3);
        chk("ovl_load", load, 3'b011);
        for (int c = 1; c <= 20; c++) begin
            w_valid = (c >= 13);
            chk("ovl_busy",  busy, 1);
            chk("ovl_wctrl", weight_ctrl, 4'b1111);
            chk("ovl_wbank", w_bank, 0);
            if (c == 13) chk("ovl_addr_first", w_addr, 0);
            if (c == 17) chk("ovl_wready_late", w_ready, 1);
            if (c == 20) chk("ovl_addr_last", w_addr, 7);
            tick();
        end
        chk("ovl_done",   done,              1);
        chk("ovl_idle",   busy,              0);
        chk("ovl_swap",   load,              3'b100);
        chk("ovl_active", active_bank,       0);
        chk("ovl_full",   dut.u_bank.full_q, 2'b01);

        // Drain bank 0, then layer on an empty bank and an illegal mode
        cmd(3'd2);
        for (int i = 0; i < 16; i++) tick();
        chk("drain_noswap", load,              0);
        chk("drain_full",   dut.u_bank.full_q, 2'b00);
        cmd(3'd2);
        chk("empty_err",  err,  1);
        chk("empty_busy", busy, 0);
        cmd(3'd5);
        chk("ill_err",  err,  1);
        chk("ill_busy", busy, 0);
        cmd(3'd0);
        chk("nop_err",  err,  0);
        chk("nop_busy", busy, 0);

        // Abort after three accepted beats
        w_valid = 1'b1;
        cmd(3'd1);
        tick();
        tick();
        tick();
        chk("abt_addr3", w_addr, 3);
        start = 1'b1;
        mode  = 3'd0;
        tick();
        start = 1'b0;
        chk("abt_busy",   busy,              0);
        chk("abt_done",   done,              0);
        chk("abt_waddr",  w_addr,            0);
        chk("abt_wready", w_ready,           0);
        chk("abt_full",   dut.u_bank.full_q, 2'b00);
        cmd(3'd1);
        chk("rld_addr",   w_addr,  0);
        chk("rld_wready", w_ready, 1);
        chk("rld_load",   load,    3'b001);
        for (int i = 0; i < 8; i++) tick();
        chk("rld_full", dut.u_bank.full_q, 2'b01);

        // Reset in the middle of an overlap
        cmd(3'd3);
        chk("ovl2_busy", busy, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_busy",   busy,              0);
        chk("mrst_wctrl",  weight_ctrl,       0);
        chk("mrst_wready", w_ready,           0);
        chk("mrst_waddr",  w_addr,            0);
        chk("mrst_wbank",  w_bank,            0);
        chk("mrst_load",   load,              0);
        chk("mrst_done",   done,              0);
        chk("mrst_err",    err,               0);
        chk("mrst_active", active_bank,       0);
        chk("mrst_full",   dut.u_bank.full_q, 2'b00);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
